src_wave_sequencer: RTL and testbench
=====================================

Name: src_wave_sequencer

Overview:
- Digital timing controller that sequences the phases of a pulse or rectangular current/voltage source.
- Phases follow the Ipulse/Irect shape: delay, rise, high, fall, low.
- Drives the source amplitude word and a phase code consumed by the behavioural source wrapper.
- Holds a shadow configuration so period timing can be reprogrammed glitch-free while running.

Parameters:
- CNT_W, 16, width of every duration field (durations are counted in clk cycles).
- LVL_W, 12, width of the amplitude word.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sequence; latches cfg_* into active registers; ignored while busy
- stop  in  1  abort sequence immediately
- cfg_load  in  1  while busy: capture cfg_* into pending registers
- cfg_rect  in  1  1 = periodic (Irect), 0 = single shot (Ipulse)
- cfg_td  in  CNT_W  delay cycles, applied once per start
- cfg_tr  in  CNT_W  rise cycles
- cfg_th  in  CNT_W  high cycles
- cfg_tf  in  CNT_W  fall cycles
- cfg_tl  in  CNT_W  low cycles
- cfg_level  in  LVL_W  high amplitude
- level_out  out  LVL_W  amplitude word
- phase  out  3  0 IDLE, 1 DELAY, 2 RISE, 3 HIGH, 4 FALL, 5 LOW
- busy  out  1  high whenever state is not IDLE
- period_tick  out  1  one-cycle pulse on the first cycle of each period
- done  out  1  one-cycle pulse on return to IDLE
- err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; active and pending registers 0; pending flag 0.
- Duration semantics: a phase of value N occupies exactly N cycles. N=0 skips the phase in the same transition, with no extra cycle.
- Phase counter loads N-1 on phase entry and decrements. The phase exits on the cycle its counter reaches 0.
- start in IDLE, sampled at edge t:
  - If tr+th+tf+tl == 0 (sum computed at CNT_W+2 bits), assert err at t+1 and stay IDLE.
  - Otherwise latch cfg_* and enter the first non-zero phase of DELAY, RISE, HIGH, FALL, LOW at t+1.
- period_tick asserts on the first cycle of the first non-zero phase after DELAY, and again at every period wrap.
- level_out is registered with the state:
  - IDLE, DELAY, LOW: 0
  - HIGH: level
  - RISE, FALL: level >> 1
- Single-shot mode (cfg_rect=0): after FALL (or the last non-zero phase before LOW), enter IDLE. LOW is not executed. done pulses on the IDLE cycle.
- Rect mode: after LOW, wrap to the first non-zero phase of RISE..LOW. DELAY is never repeated. The sequence runs until stop.
- cfg_load while busy:
  - Capture into pending registers and set the pending flag. A later load overwrites the earlier one.
  - At the period wrap, pending values are copied to active before the next phase is selected, and the flag clears.
  - A pending set with all-zero period is discarded: flag clears, active values are kept.
  - cfg_load in IDLE has no effect.
- stop while busy: next cycle IDLE, level_out 0, done pulse; the pending flag clears. stop in IDLE is ignored.
- Simultaneous events:
  - stop and start in IDLE: start wins.
  - stop and cfg_load while busy: stop wins and the load is dropped.
  - cfg_load on the wrap cycle: the new values apply at the following wrap.
- start while busy is ignored; err does not assert.
- Reset mid-sequence returns to IDLE asynchronously. No done pulse.
- Counters never wrap below 0. Maximum phase length is 2^CNT_W - 1 cycles.

Test Plan:
- Rect run: td=2, tr=1, th=3, tf=1, tl=2, level=0x100; start at cycle 0.
  - Cycles 1-2: DELAY, out 0.
  - Cycle 3: RISE, out 0x080, period_tick.
  - Cycles 4-6: HIGH, out 0x100.
  - Cycle 7: FALL, out 0x080.
  - Cycles 8-9: LOW, out 0.
  - Cycle 10: RISE with period_tick; period is 7 cycles.
- Single shot: same config with cfg_rect=0 -> FALL at cycle 7, IDLE and done at cycle 8, level_out 0, busy 0.
- Zero phases: td=0, tr=0, th=4, tf=0, tl=4, rect -> HIGH at cycles 1-4, LOW at 5-8, HIGH at 9; no RISE/FALL codes ever appear.
- Reconfig: while running test 1, cfg_load th=1 at cycle 5 -> current HIGH still ends at cycle 6; second period HIGH lasts 1 cycle (cycle 11); period becomes 5.
- Reject/abort:
  - All-zero tr/th/tf/tl with start -> err pulse at cycle 1, busy stays 0.
  - stop during HIGH -> next cycle IDLE, out 0, done=1.
- Async reset: drop rst_n mid-HIGH -> outputs 0 immediately without a clock edge; no done pulse; the next start behaves as in test 1.

Source files
------------

// File: rtl/src_wave_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : src_wave_sequencer
// Brief   : Delay/rise/high/fall/low phase sequencer for pulse and rect
//           sources, with a shadow configuration applied at period wrap.
// Rev     : 1.0  initial release
// ============================================================================
module src_wave_sequencer #(
  parameter int CNT_W = 16,
  parameter int LVL_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_load,
  input  logic             cfg_rect,
  input  logic [CNT_W-1:0] cfg_td,
  input  logic [CNT_W-1:0] cfg_tr,
  input  logic [CNT_W-1:0] cfg_th,
  input  logic [CNT_W-1:0] cfg_tf,
  input  logic [CNT_W-1:0] cfg_tl,
  input  logic [LVL_W-1:0] cfg_level,
  output logic [LVL_W-1:0] level_out,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             period_tick,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_RISE  = 3'd2,
    S_HIGH  = 3'd3,
    S_FALL  = 3'd4,
    S_LOW   = 3'd5
  } state_t;

  localparam int               SUM_W     = CNT_W + 2;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_nxt_state;
  state_t           w_seq;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [LVL_W-1:0] r_level_out;
  logic [LVL_W-1:0] w_nxt_level;
  logic             r_tick;
  logic             r_done;
  logic             r_err;
  logic             w_tick;
  logic             w_done;
  logic             w_err;
  logic             w_accept;
  logic             w_wrap;
  logic             w_take_pnd;
  logic             w_enter;

  logic             r_act_rect;
  logic [CNT_W-1:0] r_act_tr;
  logic [CNT_W-1:0] r_act_th;
  logic [CNT_W-1:0] r_act_tf;
  logic [CNT_W-1:0] r_act_tl;
  logic [LVL_W-1:0] r_act_level;

  logic             r_pnd_vld;
  logic             r_pnd_rect;
  logic [CNT_W-1:0] r_pnd_tr;
  logic [CNT_W-1:0] r_pnd_th;
  logic [CNT_W-1:0] r_pnd_tf;
  logic [CNT_W-1:0] r_pnd_tl;
  logic [LVL_W-1:0] r_pnd_level;

  logic [CNT_W-1:0] w_src_td;
  logic [CNT_W-1:0] w_src_tr;
  logic [CNT_W-1:0] w_src_th;
  logic [CNT_W-1:0] w_src_tf;
  logic [CNT_W-1:0] w_src_tl;
  logic [LVL_W-1:0] w_src_level;
  logic [SUM_W-1:0] w_cfg_sum;
  logic [SUM_W-1:0] w_pnd_sum;

  function automatic logic [SUM_W-1:0] f_sum(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b,
    input logic [CNT_W-1:0] c,
    input logic [CNT_W-1:0] d
  );
    return SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(d);
  endfunction

  // First phase at or after 'from' (within RISE..LOW) whose duration is non-zero.
  function automatic state_t f_first_nz(
    input logic [2:0]       from,
    input logic [CNT_W-1:0] tr,
    input logic [CNT_W-1:0] th,
    input logic [CNT_W-1:0] tf,
    input logic [CNT_W-1:0] tl,
    input logic             incl_low
  );
    state_t res;
    res = S_IDLE;
    if (incl_low && (from <= 3'd5) && (tl != '0)) res = S_LOW;
    if ((from <= 3'd4) && (tf != '0)) res = S_FALL;
    if ((from <= 3'd3) && (th != '0)) res = S_HIGH;
    if ((from <= 3'd2) && (tr != '0)) res = S_RISE;
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] f_dur(
    input state_t           s,
    input logic [CNT_W-1:0] td,
    input logic [CNT_W-1:0] tr,
    input logic [CNT_W-1:0] th,
    input logic [CNT_W-1:0] tf,
    input logic [CNT_W-1:0] tl
  );
    logic [CNT_W-1:0] res;
    case (s)
      S_DELAY: res = td;
      S_RISE:  res = tr;
      S_HIGH:  res = th;
      S_FALL:  res = tf;
      S_LOW:   res = tl;
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [LVL_W-1:0] f_level(
    input state_t           s,
    input logic [LVL_W-1:0] lvl
  );
    logic [LVL_W-1:0] res;
    case (s)
      S_HIGH:         res = lvl;
      S_RISE, S_FALL: res = lvl >> 1;
      default:        res = '0;
    endcase
    return res;
  endfunction

  assign w_cfg_sum = f_sum(cfg_tr, cfg_th, cfg_tf, cfg_tl);
  assign w_pnd_sum = f_sum(r_pnd_tr, r_pnd_th, r_pnd_tf, r_pnd_tl);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_seq       = S_IDLE;
    w_tick      = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_accept    = 1'b0;
    w_wrap      = 1'b0;
    w_take_pnd  = 1'b0;
    w_enter     = 1'b0;
    w_src_td    = '0;
    w_src_tr    = r_act_tr;
    w_src_th    = r_act_th;
    w_src_tf    = r_act_tf;
    w_src_tl    = r_act_tl;
    w_src_level = r_act_level;

    if (r_state == S_IDLE) begin
      if (start) begin
        if (w_cfg_sum == '0) begin
          w_err = 1'b1;
        end else begin
          w_accept    = 1'b1;
          w_enter     = 1'b1;
          w_src_td    = cfg_td;
          w_src_tr    = cfg_tr;
          w_src_th    = cfg_th;
          w_src_tf    = cfg_tf;
          w_src_tl    = cfg_tl;
          w_src_level = cfg_level;
          w_nxt_state = (cfg_td != '0) ? S_DELAY
                                       : f_first_nz(3'd2, cfg_tr, cfg_th, cfg_tf, cfg_tl, 1'b1);
          w_tick      = (w_nxt_state != S_DELAY);
        end
      end
    end else if (stop) begin
      w_nxt_state = S_IDLE;
      w_done      = 1'b1;
    end else if (r_cnt != '0) begin
      w_nxt_cnt = r_cnt - C_CNT_ONE;
    end else begin
      // Single-shot runs exclude LOW from the search, so they fall through to IDLE after FALL.
      w_seq = f_first_nz(3'(r_state) + 3'd1, r_act_tr, r_act_th, r_act_tf, r_act_tl, r_act_rect);
      if ((w_seq == S_IDLE) && r_act_rect) begin
        w_wrap     = 1'b1;
        w_take_pnd = r_pnd_vld && (w_pnd_sum != '0);
        if (w_take_pnd) begin
          w_src_tr    = r_pnd_tr;
          w_src_th    = r_pnd_th;
          w_src_tf    = r_pnd_tf;
          w_src_tl    = r_pnd_tl;
          w_src_level = r_pnd_level;
        end
        w_nxt_state = f_first_nz(3'd2, w_src_tr, w_src_th, w_src_tf, w_src_tl, 1'b1);
        w_tick      = 1'b1;
        w_enter     = 1'b1;
      end else begin
        w_nxt_state = w_seq;
        w_done      = (w_seq == S_IDLE);
        w_tick      = (r_state == S_DELAY) && (w_seq != S_IDLE);
        w_enter     = (w_seq != S_IDLE);
      end
    end

    if (w_enter) begin
      w_nxt_cnt = f_dur(w_nxt_state, w_src_td, w_src_tr, w_src_th, w_src_tf, w_src_tl) - C_CNT_ONE;
    end else if (w_nxt_state == S_IDLE) begin
      w_nxt_cnt = '0;
    end

    w_nxt_level = f_level(w_nxt_state, w_src_level);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_level_out <= '0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_act_rect  <= 1'b0;
      r_act_tr    <= '0;
      r_act_th    <= '0;
      r_act_tf    <= '0;
      r_act_tl    <= '0;
      r_act_level <= '0;
      r_pnd_vld   <= 1'b0;
      r_pnd_rect  <= 1'b0;
      r_pnd_tr    <= '0;
      r_pnd_th    <= '0;
      r_pnd_tf    <= '0;
      r_pnd_tl    <= '0;
      r_pnd_level <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_level_out <= w_nxt_level;
      r_tick      <= w_tick;
      r_done      <= w_done;
      r_err       <= w_err;

      if (w_accept) begin
        r_act_rect  <= cfg_rect;
        r_act_tr    <= cfg_tr;
        r_act_th    <= cfg_th;
        r_act_tf    <= cfg_tf;
        r_act_tl    <= cfg_tl;
        r_act_level <= cfg_level;
      end else if (w_take_pnd) begin
        r_act_rect  <= r_pnd_rect;
        r_act_tr    <= r_pnd_tr;
        r_act_th    <= r_pnd_th;
        r_act_tf    <= r_pnd_tf;
        r_act_tl    <= r_pnd_tl;
        r_act_level <= r_pnd_level;
      end

      // A load sampled on the wrap edge survives the clear and waits for the next wrap.
      if (w_nxt_state == S_IDLE) begin
        r_pnd_vld <= 1'b0;
      end else if (cfg_load && (r_state != S_IDLE)) begin
        r_pnd_vld   <= 1'b1;
        r_pnd_rect  <= cfg_rect;
        r_pnd_tr    <= cfg_tr;
        r_pnd_th    <= cfg_th;
        r_pnd_tf    <= cfg_tf;
        r_pnd_tl    <= cfg_tl;
        r_pnd_level <= cfg_level;
      end else if (w_wrap) begin
        r_pnd_vld <= 1'b0;
      end
    end
  end

  assign level_out   = r_level_out;
  assign phase       = r_state;
  assign busy        = (r_state != S_IDLE);
  assign period_tick = r_tick;
  assign done        = r_done;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_src_wave_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_src_wave_sequencer
// Brief   : Directed and randomized bench; expected waveform is expanded into a
//           per-cycle queue from the configured phase durations.
// Rev     : 1.0  initial release
// ============================================================================
module tb_src_wave_sequencer;
  localparam int CNT_W = 16;
  localparam int LVL_W = 12;

  localparam logic [2:0] PH_DELAY = 3'd1;
  localparam logic [2:0] PH_RISE  = 3'd2;
  localparam logic [2:0] PH_HIGH  = 3'd3;
  localparam logic [2:0] PH_FALL  = 3'd4;
  localparam logic [2:0] PH_LOW   = 3'd5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             cfg_load = 1'b0;
  logic             cfg_rect = 1'b0;
  logic [CNT_W-1:0] cfg_td = '0;
  logic [CNT_W-1:0] cfg_tr = '0;
  logic [CNT_W-1:0] cfg_th = '0;
  logic [CNT_W-1:0] cfg_tf = '0;
  logic [CNT_W-1:0] cfg_tl = '0;
  logic [LVL_W-1:0] cfg_level = '0;
  logic [LVL_W-1:0] level_out;
  logic [2:0]       phase;
  logic             busy;
  logic             period_tick;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  src_wave_sequencer #(.CNT_W(CNT_W), .LVL_W(LVL_W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .cfg_load    (cfg_load),
    .cfg_rect    (cfg_rect),
    .cfg_td      (cfg_td),
    .cfg_tr      (cfg_tr),
    .cfg_th      (cfg_th),
    .cfg_tf      (cfg_tf),
    .cfg_tl      (cfg_tl),
    .cfg_level   (cfg_level),
    .level_out   (level_out),
    .phase       (phase),
    .busy        (busy),
    .period_tick (period_tick),
    .done        (done),
    .err         (err)
  );

  typedef struct packed {
    logic [2:0]       ph;
    logic [LVL_W-1:0] lv;
    logic             tk;
  } ent_t;

  ent_t             exp_q[$];
  int               n_checks = 0;
  int               n_errors = 0;
  logic             m_done = 1'b0;
  logic             m_err = 1'b0;
  bit               a_rect;
  int               a_tr, a_th, a_tf, a_tl;
  logic [LVL_W-1:0] a_lvl;
  bit               p_vld = 1'b0;
  bit               p_rect;
  int               p_tr, p_th, p_tf, p_tl;
  logic [LVL_W-1:0] p_lvl;
  int               cyc = 0;
  int               done_cyc = -1;
  bit               seen_rf = 1'b0;
  int               tick_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t cyc=%0d)", tag, obs, exp, $time, cyc);
    end
  endtask

  task automatic push_n(input logic [2:0] ph, input logic [LVL_W-1:0] lv, input int n, inout bit first);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e.ph = ph;
      e.lv = lv;
      e.tk = first;
      exp_q.push_back(e);
      first = 1'b0;
    end
  endtask

  // One period expands to tr RISE, th HIGH, tf FALL (and tl LOW in rect mode) cycles.
  task automatic push_period();
    bit first = 1'b1;
    push_n(PH_RISE, a_lvl >> 1, a_tr, first);
    push_n(PH_HIGH, a_lvl,      a_th, first);
    push_n(PH_FALL, a_lvl >> 1, a_tf, first);
    if (a_rect) push_n(PH_LOW, '0, a_tl, first);
  endtask

  task automatic model_edge();
    bit nf = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (exp_q.size() == 0) begin
      if (start) begin
        if (int'(cfg_tr) + int'(cfg_th) + int'(cfg_tf) + int'(cfg_tl) == 0) begin
          m_err = 1'b1;
        end else begin
          a_rect = cfg_rect;
          a_tr = int'(cfg_tr); a_th = int'(cfg_th); a_tf = int'(cfg_tf); a_tl = int'(cfg_tl);
          a_lvl = cfg_level;
          push_n(PH_DELAY, '0, int'(cfg_td), nf);
          push_period();
          p_vld = 1'b0;
        end
      end
    end else if (stop) begin
      exp_q.delete();
      m_done = 1'b1;
      p_vld  = 1'b0;
    end else begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        if (a_rect) begin
          if (p_vld && (p_tr + p_th + p_tf + p_tl != 0)) begin
            a_rect = p_rect; a_tr = p_tr; a_th = p_th; a_tf = p_tf; a_tl = p_tl; a_lvl = p_lvl;
          end
          p_vld = 1'b0;
          push_period();
        end else begin
          m_done = 1'b1;
          p_vld  = 1'b0;
        end
      end
      if (cfg_load && exp_q.size() != 0) begin
        p_vld = 1'b1; p_rect = cfg_rect;
        p_tr = int'(cfg_tr); p_th = int'(cfg_th); p_tf = int'(cfg_tf); p_tl = int'(cfg_tl);
        p_lvl = cfg_level;
      end
    end
  endtask

  task automatic check_outputs();
    ent_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q[0];
    check("phase",       32'(phase),       32'(e.ph));
    check("level_out",   32'(level_out),   32'(e.lv));
    check("busy",        32'(busy),        32'(exp_q.size() > 0));
    check("period_tick", 32'(period_tick), 32'(e.tk));
    check("done",        32'(done),        32'(m_done));
    check("err",         32'(err),         32'(m_err));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    if (period_tick) tick_cyc.push_back(cyc);
    if (done) done_cyc = cyc;
    if (phase == PH_RISE || phase == PH_FALL) seen_rf = 1'b1;
  endtask

  task automatic set_cfg(input int td, input int tr, input int th, input int tf, input int tl,
                         input int lvl, input bit rect);
    cfg_td = CNT_W'(td); cfg_tr = CNT_W'(tr); cfg_th = CNT_W'(th);
    cfg_tf = CNT_W'(tf); cfg_tl = CNT_W'(tl);
    cfg_level = LVL_W'(lvl); cfg_rect = rect;
  endtask

  task automatic begin_run();
    cyc = 0; done_cyc = -1; seen_rf = 1'b0; tick_cyc.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic abort_run();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic check_test1_ticks(input string tag);
    check({tag, "_ticks"}, 32'(tick_cyc.size()), 32'd3);
    if (tick_cyc.size() >= 2) begin
      check({tag, "_first_tick"}, 32'(tick_cyc[0]), 32'd3);
      check({tag, "_period"}, 32'(tick_cyc[1] - tick_cyc[0]), 32'd7);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Rect run
    set_cfg(2, 1, 3, 1, 2, 'h100, 1'b1);
    begin_run();
    repeat (16) step();
    check_test1_ticks("rect");
    abort_run();

    // Single shot
    set_cfg(2, 1, 3, 1, 2, 'h100, 1'b0);
    begin_run();
    repeat (9) step();
    check("ss_done_cyc", 32'(done_cyc), 32'd8);
    check("ss_busy_end", 32'(busy), 32'd0);

    // Zero-length phases are skipped
    set_cfg(0, 0, 4, 0, 4, 'h3ff, 1'b1);
    begin_run();
    repeat (12) step();
    check("zp_no_rise_fall", 32'(seen_rf), 32'd0);
    if (tick_cyc.size() >= 2) check("zp_period", 32'(tick_cyc[1] - tick_cyc[0]), 32'd8);
    else check("zp_ticks", 32'(tick_cyc.size()), 32'd2);
    abort_run();

    // Reconfiguration mid-HIGH takes effect at the next wrap
    set_cfg(2, 1, 3, 1, 2, 'h100, 1'b1);
    begin_run();
    while (cyc < 17) begin
      if (cyc == 5) begin
        cfg_th = CNT_W'(1);
        cfg_load = 1'b1;
      end
      step();
      cfg_load = 1'b0;
    end
    check("rc_ticks", 32'(tick_cyc.size()), 32'd3);
    if (tick_cyc.size() >= 3) begin
      check("rc_period1", 32'(tick_cyc[1] - tick_cyc[0]), 32'd7);
      check("rc_period2", 32'(tick_cyc[2] - tick_cyc[1]), 32'd5);
    end
    abort_run();

    // Rejected start, stop in IDLE, start+stop in IDLE
    set_cfg(3, 0, 0, 0, 0, 'h055, 1'b1);
    begin_run();
    check("rej_err", 32'(err), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    set_cfg(2, 1, 3, 1, 2, 'h100, 1'b1);
    stop = 1'b1;
    begin_run();
    stop = 1'b0;
    check("start_wins_busy", 32'(busy), 32'd1);
    while (cyc < 5) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_done", 32'(done), 32'd1);
    check("stop_phase", 32'(phase), 32'd0);
    step();

    // Asynchronous reset during HIGH
    begin_run();
    while (cyc < 5) step();
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_phase", 32'(phase), 32'd0);
    check("ar_level", 32'(level_out), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    exp_q.delete();
    p_vld = 1'b0; m_done = 1'b0; m_err = 1'b0;
    @(posedge clk);
    #1;
    check("ar_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    begin_run();
    repeat (16) step();
    check_test1_ticks("post_reset");
    abort_run();

    // Randomized runs with stops, reloads and spurious starts
    for (int r = 0; r < 60; r++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4095),
              1'($urandom_range(0, 1)));
      if (!cfg_rect && (cfg_tr + cfg_th + cfg_tf == '0)) cfg_th = CNT_W'(1);
      if ($urandom_range(0, 9) == 0) begin
        cfg_tr = '0; cfg_th = '0; cfg_tf = '0; cfg_tl = '0;
      end
      stop = ($urandom_range(0, 4) == 0);
      begin_run();
      stop = 1'b0;
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
        stop  = ($urandom_range(0, 29) == 0);
        start = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 5) == 0) begin
          cfg_load = 1'b1;
          cfg_rect = 1'b1;
          cfg_tr = CNT_W'($urandom_range(0, 3));
          cfg_th = CNT_W'($urandom_range(0, 3));
          cfg_tf = CNT_W'($urandom_range(0, 3));
          cfg_tl = CNT_W'($urandom_range(0, 3));
          cfg_level = LVL_W'($urandom_range(0, 4095));
        end
        step();
        stop = 1'b0; start = 1'b0; cfg_load = 1'b0;
      end
      if (exp_q.size() > 0) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
      end
      cfg_load = 1'($urandom_range(0, 1));
      step();
      cfg_load = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
